// File: rtl/mvm_rr_arbiter_if.sv
// Handshake bundle between the requesters, the round-robin arbiter and the shared
// matrix-vector engine. The slave view is the arbiter; the master view is everything around it.
interface mvm_rr_arbiter_if #(
  parameter int unsigned N    = 2,
  parameter int unsigned W_KX = 576,
  parameter int unsigned W_YB = 152
);
  // Requester -> arbiter (K/X bundles)
  logic [N-1:0]      s_kx_tvalid;
  logic [N-1:0]      s_kx_tready;
  logic [N*W_KX-1:0] s_kx_tdata;
  // Arbiter -> engine
  logic              m_kx_tvalid;
  logic              m_kx_tready;
  logic [W_KX-1:0]   m_kx_tdata;
  // Engine -> arbiter (Y results)
  logic              s_y_tvalid;
  logic              s_y_tready;
  logic [W_YB-1:0]   s_y_tdata;
  // Arbiter -> requesters
  logic [N-1:0]      m_y_tvalid;
  logic [N-1:0]      m_y_tready;
  logic [W_YB-1:0]   m_y_tdata;

  modport slave (
    input  s_kx_tvalid, s_kx_tdata, m_kx_tready, s_y_tvalid, s_y_tdata, m_y_tready,
    output s_kx_tready, m_kx_tvalid, m_kx_tdata, s_y_tready, m_y_tvalid, m_y_tdata
  );

  modport master (
    output s_kx_tvalid, s_kx_tdata, m_kx_tready, s_y_tvalid, s_y_tdata, m_y_tready,
    input  s_kx_tready, m_kx_tvalid, m_kx_tdata, s_y_tready, m_y_tvalid, m_y_tdata
  );
endinterface

// File: rtl/mvm_rr_arbiter.sv
// Round-robin arbiter sharing one matrix-vector engine among N requesters.
// Granted K/X bundles are registered and forwarded to the engine; an in-order tag FIFO
// remembers the issuer of each request so every Y result is steered back to it.
module mvm_rr_arbiter #(
  parameter int unsigned N            = 2,
  parameter int unsigned R            = 8,
  parameter int unsigned C            = 8,
  parameter int unsigned W_X          = 8,
  parameter int unsigned W_K          = 8,
  parameter int unsigned MAX_INFLIGHT = 4,
  localparam int unsigned W_I         = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  mvm_rr_arbiter_if.slave       bus,
  output logic [W_I-1:0]        inflight,
  output logic                  err_orphan
);

  localparam int unsigned W_KX = R * C * W_K + C * W_X;
  localparam int unsigned W_T  = $clog2(N);
  localparam int unsigned W_P  = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  state_e            state_q;
  logic [W_T-1:0]    rr_ptr_q;
  logic [W_T-1:0]    tag_q;
  logic              kx_valid_q;
  logic [W_KX-1:0]   kx_data_q;
  logic [W_P-1:0]    wr_ptr_q;
  logic [W_P-1:0]    rd_ptr_q;
  logic [W_I-1:0]    count_q;
  logic              err_q;
  logic [W_T-1:0]    tag_mem [MAX_INFLIGHT];

  logic              any_req;
  logic [W_T-1:0]    win;
  logic [W_T-1:0]    cand;
  logic              grant;
  logic [W_KX-1:0]   grant_data;
  logic [W_T-1:0]    next_ptr;
  logic [W_T-1:0]    head;
  logic              nonempty;
  logic              push;
  logic              pop;

  // Pick the first valid requester at or after the RR pointer; scanning from the far end
  // lets the nearest candidate overwrite the others.
  always_comb begin
    win     = '0;
    cand    = '0;
    any_req = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = W_T'((int'(rr_ptr_q) + k) % N);
      if (bus.s_kx_tvalid[cand]) begin
        win     = cand;
        any_req = 1'b1;
      end
    end
  end

  // Grant only from IDLE with tag space left; rst gates the pulse so ready is 0 in reset.
  always_comb begin
    grant           = (state_q == StIdle) && !rst && any_req &&
                      (count_q < W_I'(MAX_INFLIGHT));
    grant_data      = bus.s_kx_tdata[W_KX * win +: W_KX];
    bus.s_kx_tready = '0;
    for (int i = 0; i < N; i++) begin
      bus.s_kx_tready[i] = grant && (win == W_T'(i));
    end
    next_ptr        = (tag_q == W_T'(N - 1)) ? '0 : tag_q + 1'b1;
    push            = kx_valid_q && bus.m_kx_tready;
  end

  // Steer the engine result to the requester at the FIFO head; others' ready is ignored.
  always_comb begin
    head           = tag_mem[rd_ptr_q];
    nonempty       = (count_q != '0);
    bus.s_y_tready = nonempty && bus.m_y_tready[head];
    bus.m_y_tvalid = '0;
    for (int i = 0; i < N; i++) begin
      bus.m_y_tvalid[i] = bus.s_y_tvalid && nonempty && (head == W_T'(i));
    end
    bus.m_y_tdata  = bus.s_y_tdata;
    pop            = bus.s_y_tvalid && bus.s_y_tready;
  end

  // Request-side FSM: capture the winner, hold it stable until the engine takes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      kx_valid_q <= 1'b0;
      kx_data_q  <= '0;
      tag_q      <= '0;
      rr_ptr_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (grant) begin
            kx_data_q  <= grant_data;
            tag_q      <= win;
            kx_valid_q <= 1'b1;
            state_q    <= StSend;
          end
        end
        StSend: begin
          if (bus.m_kx_tready) begin
            kx_valid_q <= 1'b0;
            rr_ptr_q   <= next_ptr;
            state_q    <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Tag FIFO pointers and occupancy; simultaneous push and pop leave the count unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Tag storage; only entries between rd and wr pointers are ever read meaningfully.
  always_ff @(posedge clk) begin
    if (push) tag_mem[wr_ptr_q] <= tag_q;
  end

  // Sticky flag: the engine offered a result nobody is waiting for.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (bus.s_y_tvalid && !nonempty) begin
      err_q <= 1'b1;
    end
  end

  assign bus.m_kx_tvalid = kx_valid_q;
  assign bus.m_kx_tdata  = kx_data_q;
  assign inflight        = count_q;
  assign err_orphan      = err_q;

endmodule

// File: tb/tb_mvm_rr_arbiter.sv
// Bench for mvm_rr_arbiter: two requesters, a 3-cycle engine model with controllable
// tready/hold, and a scoreboard of expected grants and routed results.
module tb_mvm_rr_arbiter;
  localparam int unsigned N = 2, R = 2, C = 2, W_X = 8, W_K = 8, MAX_INFLIGHT = 4;
  localparam int unsigned W_KX = 48, W_Y = 17, W_YB = 34;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] inflight;
  logic       err_orphan;

  mvm_rr_arbiter_if #(.N(N), .W_KX(W_KX), .W_YB(W_YB)) bus ();

  mvm_rr_arbiter #(
    .N(N), .R(R), .C(C), .W_X(W_X), .W_K(W_K), .MAX_INFLIGHT(MAX_INFLIGHT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .inflight(inflight),
    .err_orphan(err_orphan)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int grants = 0;
  int cyc = 0;

  logic            eng_hold = 1'b0;
  logic            inj = 1'b0;
  logic            head_avail = 1'b0;
  logic [W_YB-1:0] head_data = '0;

  logic [W_KX-1:0] rq0[$];
  logic [W_KX-1:0] rq1[$];
  logic [W_YB-1:0] eq_data[$];
  int              eq_at[$];
  int              exp_grant[$];
  int              exp_dst[$];
  logic [W_YB-1:0] exp_y[$];

  assign bus.s_y_tvalid = inj | (head_avail & ~eng_hold);
  assign bus.s_y_tdata  = head_data;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [W_KX-1:0] kx(input int k00, k01, k10, k11, x0, x1);
    return {8'(x1), 8'(x0), 8'(k11), 8'(k10), 8'(k01), 8'(k00)};
  endfunction

  function automatic logic [W_YB-1:0] yv(input int y0, y1);
    return {17'(y1), 17'(y0)};
  endfunction

  function automatic logic [W_YB-1:0] eng_calc(input logic [W_KX-1:0] d);
    logic [W_Y-1:0] y0, y1;
    y0 = W_Y'(d[7:0]) * W_Y'(d[39:32]) + W_Y'(d[15:8]) * W_Y'(d[47:40]);
    y1 = W_Y'(d[23:16]) * W_Y'(d[39:32]) + W_Y'(d[31:24]) * W_Y'(d[47:40]);
    return {y1, y0};
  endfunction

  task automatic refresh();
    logic [W_KX-1:0] d0, d1;
    d0 = (rq0.size() != 0) ? rq0[0] : W_KX'(0);
    d1 = (rq1.size() != 0) ? rq1[0] : W_KX'(0);
    bus.s_kx_tvalid = {rq1.size() != 0, rq0.size() != 0};
    bus.s_kx_tdata  = {d1, d0};
    head_avail = 1'b0;
    head_data  = '0;
    if (eq_data.size() != 0) begin
      head_avail = (cyc >= eq_at[0]);
      head_data  = eq_data[0];
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic req(input int r, input logic [W_KX-1:0] d);
    if (r == 0) rq0.push_back(d);
    else rq1.push_back(d);
  endtask

  task automatic expect_res(input int dst, input logic [W_YB-1:0] y);
    exp_dst.push_back(dst);
    exp_y.push_back(y);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_grant.size() != 0 || exp_dst.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(name, 64'(exp_grant.size() + exp_dst.size()), 64'd0);
    tick();
  endtask

  task automatic wait_kx_valid(input string name);
    int n = 0;
    while (!bus.m_kx_tvalid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check(name, 64'(bus.m_kx_tvalid), 64'd1);
  endtask

  // Requester and engine agent: handshakes observed at negedge, applied just after posedge.
  initial begin : agent
    logic [1:0]      s_g;
    logic            s_kx, s_y, s_rst;
    logic [W_KX-1:0] s_kxd;
    forever begin
      @(negedge clk);
      s_g   = bus.s_kx_tready & bus.s_kx_tvalid;
      s_kx  = bus.m_kx_tvalid & bus.m_kx_tready;
      s_kxd = bus.m_kx_tdata;
      s_y   = bus.s_y_tvalid & bus.s_y_tready;
      s_rst = rst;
      @(posedge clk);
      #1;
      cyc++;
      if (s_rst) begin
        eq_data.delete();
        eq_at.delete();
      end else begin
        if (s_g[0] && rq0.size() != 0) void'(rq0.pop_front());
        if (s_g[1] && rq1.size() != 0) void'(rq1.pop_front());
        if (s_y && eq_data.size() != 0) begin
          void'(eq_data.pop_front());
          void'(eq_at.pop_front());
        end
        if (s_kx) begin
          eq_data.push_back(eng_calc(s_kxd));
          eq_at.push_back(cyc + 3);
        end
      end
      refresh();
    end
  end

  // Scoreboard monitor: every grant pulse and every delivered result pops an expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.s_kx_tready != 2'b00) begin
        grants++;
        if (exp_grant.size() == 0) check("unexpected_grant", 64'(bus.s_kx_tready), 64'd0);
        else check("grant_order", 64'(bus.s_kx_tready), 64'd1 << exp_grant.pop_front());
      end
      if ((bus.m_y_tvalid & bus.m_y_tready) != 2'b00) begin
        if (exp_dst.size() == 0) begin
          check("unexpected_result", 64'(bus.m_y_tvalid), 64'd0);
        end else begin
          check("result_route", 64'(bus.m_y_tvalid), 64'd1 << exp_dst.pop_front());
          check("result_data", 64'(bus.m_y_tdata), 64'(exp_y.pop_front()));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog timeout");
  end

  initial begin : stim
    int g0;
    int n;
    rst = 1'b1;
    bus.m_kx_tready = 1'b1;
    bus.m_y_tready  = 2'b11;
    refresh();

    // Reset state
    @(negedge clk);
    check("rst_s_kx_tready", 64'(bus.s_kx_tready), 64'd0);
    check("rst_m_kx_tvalid", 64'(bus.m_kx_tvalid), 64'd0);
    check("rst_m_kx_tdata", 64'(bus.m_kx_tdata), 64'd0);
    check("rst_inflight", 64'(inflight), 64'd0);
    check("rst_err_orphan", 64'(err_orphan), 64'd0);
    check("rst_s_y_tready", 64'(bus.s_y_tready), 64'd0);
    check("rst_m_y_tvalid", 64'(bus.m_y_tvalid), 64'd0);
    tick();
    rst = 1'b0;
    tick();

    // 1: single request from requester 0
    g0 = grants;
    req(0, kx(1, 2, 3, 4, 5, 6));
    exp_grant.push_back(0);
    expect_res(0, yv(17, 39));
    refresh();
    drain("t1_drain");
    check("t1_one_grant", 64'(grants - g0), 64'd1);

    // 2: both requesters valid back to back, from a fresh reset
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    req(0, kx(2, 0, 0, 2, 7, 9));
    req(0, kx(1, 1, 1, 1, 10, 20));
    req(1, kx(255, 255, 255, 255, 255, 255));
    req(1, kx(0, 1, 1, 0, 3, 4));
    exp_grant.push_back(0); exp_grant.push_back(1);
    exp_grant.push_back(0); exp_grant.push_back(1);
    expect_res(0, yv(14, 18));
    expect_res(1, yv(130050, 130050));
    expect_res(0, yv(30, 30));
    expect_res(1, yv(4, 3));
    refresh();
    drain("t2_drain");

    // 3: engine stalls the send for 10 cycles
    bus.m_kx_tready = 1'b0;
    req(0, kx(3, 0, 0, 5, 2, 2));
    exp_grant.push_back(0);
    expect_res(0, yv(6, 10));
    refresh();
    wait_kx_valid("t3_send");
    tick();
    req(1, kx(1, 0, 0, 1, 8, 9));
    exp_grant.push_back(1);
    expect_res(1, yv(8, 9));
    refresh();
    repeat (10) begin
      @(negedge clk);
      check("t3_hold_valid", 64'(bus.m_kx_tvalid), 64'd1);
      check("t3_hold_data", 64'(bus.m_kx_tdata), 64'(kx(3, 0, 0, 5, 2, 2)));
      check("t3_no_grant", 64'(bus.s_kx_tready), 64'd0);
    end
    tick();
    bus.m_kx_tready = 1'b1;
    @(negedge clk);
    check("t3_hs_no_grant", 64'(bus.s_kx_tready), 64'd0);
    @(negedge clk);
    check("t3_resume_grant", 64'(bus.s_kx_tready), 64'd2);
    tick();
    drain("t3_drain");

    // 4: engine holds its results until the tag FIFO is full
    eng_hold = 1'b1;
    req(0, kx(1, 2, 3, 4, 5, 6));
    req(0, kx(1, 1, 1, 1, 10, 20));
    req(0, kx(1, 0, 0, 1, 8, 9));
    req(1, kx(2, 0, 0, 2, 7, 9));
    req(1, kx(255, 255, 255, 255, 255, 255));
    exp_grant.push_back(0); exp_grant.push_back(1); exp_grant.push_back(0);
    exp_grant.push_back(1); exp_grant.push_back(0);
    expect_res(0, yv(17, 39));
    expect_res(1, yv(14, 18));
    expect_res(0, yv(30, 30));
    expect_res(1, yv(130050, 130050));
    expect_res(0, yv(8, 9));
    refresh();
    g0 = grants;
    repeat (14) @(negedge clk);
    check("t4_inflight_full", 64'(inflight), 64'd4);
    check("t4_four_grants", 64'(grants - g0), 64'd4);
    repeat (3) begin
      check("t4_full_no_grant", 64'(bus.s_kx_tready), 64'd0);
      @(negedge clk);
    end
    tick();
    eng_hold = 1'b0;
    @(negedge clk);
    n = 0;
    while (!(bus.s_y_tvalid && bus.s_y_tready) && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("t4_first_pop", 64'(bus.s_y_tvalid && bus.s_y_tready), 64'd1);
    check("t4_pop_cycle_no_grant", 64'(bus.s_kx_tready), 64'd0);
    @(negedge clk);
    check("t4_regrant", 64'(bus.s_kx_tready), 64'd1);
    check("t4_inflight_after_pop", 64'(inflight), 64'd3);
    tick();
    drain("t4_drain");

    // 5: requester 1 not ready while its result is at the head
    bus.m_y_tready = 2'b01;
    req(1, kx(4, 4, 1, 2, 1, 1));
    req(0, kx(0, 1, 1, 0, 3, 4));
    exp_grant.push_back(1); exp_grant.push_back(0);
    expect_res(1, yv(8, 3));
    expect_res(0, yv(4, 3));
    refresh();
    @(negedge clk);
    n = 0;
    while (!bus.s_y_tvalid && n < 20) begin
      @(negedge clk);
      n++;
    end
    repeat (3) begin
      check("t5_route_head", 64'(bus.m_y_tvalid), 64'd2);
      check("t5_engine_stall", 64'(bus.s_y_tready), 64'd0);
      @(negedge clk);
    end
    check("t5_inflight", 64'(inflight), 64'd2);
    tick();
    bus.m_y_tready = 2'b11;
    drain("t5_drain");

    // 6: orphan result, then reset in the middle of a send
    @(negedge clk);
    check("t6_empty", 64'(inflight), 64'd0);
    tick();
    inj = 1'b1;
    @(negedge clk);
    check("t6_orphan_stall", 64'(bus.s_y_tready), 64'd0);
    check("t6_orphan_no_route", 64'(bus.m_y_tvalid), 64'd0);
    tick();
    inj = 1'b0;
    @(negedge clk);
    check("t6_err_set", 64'(err_orphan), 64'd1);
    repeat (5) @(negedge clk);
    check("t6_err_sticky", 64'(err_orphan), 64'd1);
    tick();
    bus.m_kx_tready = 1'b0;
    req(0, kx(1, 2, 3, 4, 5, 6));
    exp_grant.push_back(0);
    refresh();
    wait_kx_valid("t6_send");
    tick();
    check("t6_in_send", 64'(bus.m_kx_tvalid), 64'd1);
    rst = 1'b1;
    #1;
    check("t6_rst_valid", 64'(bus.m_kx_tvalid), 64'd0);
    check("t6_rst_data", 64'(bus.m_kx_tdata), 64'd0);
    check("t6_rst_err", 64'(err_orphan), 64'd0);
    check("t6_rst_inflight", 64'(inflight), 64'd0);
    tick();
    tick();
    rst = 1'b0;
    bus.m_kx_tready = 1'b1;
    req(0, kx(2, 0, 0, 2, 7, 9));
    req(1, kx(0, 1, 1, 0, 3, 4));
    exp_grant.push_back(0); exp_grant.push_back(1);
    expect_res(0, yv(14, 18));
    expect_res(1, yv(4, 3));
    refresh();
    drain("t6_drain");

    check("end_grants_empty", 64'(exp_grant.size()), 64'd0);
    check("end_results_empty", 64'(exp_dst.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
